// File: rtl/lc3_pipe_ctrl.sv
// LC3 pipeline controller: stage enables, branch resolution, operand bypass
// selects and data-memory access sequencing, all from registered outputs.
// Optional feature macro: LC3_PIPE_CTRL_BYPASS_EN (forwarding on; when undefined
// every would-be bypass becomes a single-cycle decode stall instead).
module lc3_pipe_ctrl #(
   parameter int unsigned FILL_DEPTH   = 3,
   parameter int unsigned BR_FLUSH_CYC = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        complete_instr,
   input  logic        complete_data,
   input  logic [15:0] IR,
   input  logic [15:0] IR_Exec,
   input  logic [2:0]  NZP,
   input  logic [2:0]  psr,
   output logic        enable_updatePC,
   output logic        enable_fetch,
   output logic        enable_decode,
   output logic        enable_execute,
   output logic        enable_writeback,
   output logic        br_taken,
   output logic        bypass_alu_1,
   output logic        bypass_alu_2,
   output logic        bypass_mem_1,
   output logic        bypass_mem_2,
   output logic [1:0]  mem_state
);

   localparam int unsigned CNT_W = 4;
   localparam logic [1:0] MS_READ  = 2'b00;
   localparam logic [1:0] MS_IND   = 2'b01;
   localparam logic [1:0] MS_WRITE = 2'b10;
   localparam logic [1:0] MS_IDLE  = 2'b11;

   typedef enum logic [1:0] {StFill, StRun, StMem, StFlush} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc;
   logic             mem_is_load;

   logic [3:0] op_d;
   logic [3:0] op_x;
   logic       d_alu;
   logic       x_alu, x_ld, x_ldi, x_st, x_sti, x_ld_any, x_mem, x_br, x_jmp;
   logic       br_cond;
   logic       match_1, match_2;
   logic       raw_alu_1, raw_alu_2, raw_mem_1, raw_mem_2;
   logic       hazard;
   logic       run_stall;
   logic       exit_stall;
   logic       unused_bits;

   assign op_d = IR[15:12];
   assign op_x = IR_Exec[15:12];

   assign d_alu    = (op_d == 4'b0001) || (op_d == 4'b0101) || (op_d == 4'b1001);
   assign x_alu    = (op_x == 4'b0001) || (op_x == 4'b0101) || (op_x == 4'b1001);
   assign x_ld     = (op_x == 4'b0010) || (op_x == 4'b0110);
   assign x_ldi    = (op_x == 4'b1010);
   assign x_st     = (op_x == 4'b0011) || (op_x == 4'b0111);
   assign x_sti    = (op_x == 4'b1011);
   assign x_ld_any = x_ld || x_ldi;
   assign x_mem    = x_ld || x_ldi || x_st || x_sti;
   assign x_br     = (op_x == 4'b0000);
   assign x_jmp    = (op_x == 4'b1100);
   assign br_cond  = x_br ? |(NZP & psr) : x_jmp;

   // Register-number matches between the decode sources and the execute destination
   assign match_1   = (IR_Exec[11:9] == IR[8:6]);
   assign match_2   = !IR[5] && (IR_Exec[11:9] == IR[2:0]);
   assign raw_alu_1 = d_alu && x_alu && match_1;
   assign raw_alu_2 = d_alu && x_alu && match_2;
   assign raw_mem_1 = d_alu && x_ld_any && match_1;
   assign raw_mem_2 = d_alu && x_ld_any && match_2;
   assign hazard    = raw_alu_1 || raw_alu_2 || raw_mem_1 || raw_mem_2;

   assign cnt_inc     = cnt + 1'b1;
   assign unused_bits = ^{IR[11:9], IR[4:3], IR_Exec[8:0]};

`ifdef LC3_PIPE_CTRL_BYPASS_EN
   assign run_stall  = 1'b0;
   assign exit_stall = 1'b0;
`else
   // Without forwarding a dependent ALU op waits one cycle in decode
   assign run_stall  = enable_decode && hazard;
   assign exit_stall = hazard;
   assign bypass_alu_1 = 1'b0;
   assign bypass_alu_2 = 1'b0;
   assign bypass_mem_1 = 1'b0;
   assign bypass_mem_2 = 1'b0;
`endif

   // Controller FSM with all outputs registered
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state            <= StFill;
         cnt              <= '0;
         mem_is_load      <= 1'b0;
         enable_updatePC  <= 1'b1;
         enable_fetch     <= 1'b1;
         enable_decode    <= 1'b0;
         enable_execute   <= 1'b0;
         enable_writeback <= 1'b0;
         br_taken         <= 1'b0;
         mem_state        <= MS_IDLE;
`ifdef LC3_PIPE_CTRL_BYPASS_EN
         bypass_alu_1     <= 1'b0;
         bypass_alu_2     <= 1'b0;
         bypass_mem_1     <= 1'b0;
         bypass_mem_2     <= 1'b0;
`endif
      end else begin
         br_taken <= 1'b0;
`ifdef LC3_PIPE_CTRL_BYPASS_EN
         bypass_alu_1 <= 1'b0;
         bypass_alu_2 <= 1'b0;
         bypass_mem_1 <= 1'b0;
         bypass_mem_2 <= 1'b0;
`endif
         unique case (state)
            StFill: begin
               cnt           <= cnt_inc;
               enable_decode <= 1'b1;
               if (cnt_inc >= CNT_W'(2)) enable_execute <= 1'b1;
               if (cnt_inc >= CNT_W'(FILL_DEPTH)) begin
                  enable_execute   <= 1'b1;
                  enable_writeback <= 1'b1;
                  state            <= StRun;
               end
            end
            StRun: begin
               if (enable_execute && x_mem) begin
                  // Memory op wins over an instruction-fetch wait
                  state       <= StMem;
                  mem_is_load <= x_ld_any;
                  {enable_updatePC, enable_fetch, enable_decode, enable_execute,
                   enable_writeback} <= 5'b00000;
                  if (x_ldi || x_sti) mem_state <= MS_IND;
                  else if (x_ld)      mem_state <= MS_READ;
                  else                mem_state <= MS_WRITE;
               end else if (enable_execute && br_cond) begin
                  br_taken <= 1'b1;
                  state    <= StFlush;
                  cnt      <= CNT_W'(1);
                  {enable_updatePC, enable_fetch, enable_decode, enable_execute,
                   enable_writeback} <= 5'b11000;
               end else begin
`ifdef LC3_PIPE_CTRL_BYPASS_EN
                  bypass_alu_1 <= enable_decode && raw_alu_1;
                  bypass_alu_2 <= enable_decode && raw_alu_2;
                  bypass_mem_1 <= enable_decode && raw_mem_1;
                  bypass_mem_2 <= enable_decode && raw_mem_2;
`endif
                  if (run_stall) begin
                     {enable_updatePC, enable_fetch, enable_decode, enable_execute} <= 4'b0001;
                  end else if (complete_instr) begin
                     {enable_updatePC, enable_fetch, enable_decode, enable_execute,
                      enable_writeback} <= 5'b11111;
                  end else begin
                     {enable_updatePC, enable_fetch, enable_decode, enable_execute} <= 4'b0000;
                  end
               end
            end
            StMem: begin
               if (complete_data) begin
                  if (mem_state == MS_IND) begin
                     mem_state <= mem_is_load ? MS_READ : MS_WRITE;
                  end else begin
                     // Final beat: pipeline resumes, loads write back, forward load data
                     mem_state        <= MS_IDLE;
                     state            <= StRun;
                     enable_writeback <= mem_is_load;
                     if (exit_stall) begin
                        {enable_updatePC, enable_fetch, enable_decode, enable_execute} <= 4'b0001;
                     end else begin
                        {enable_updatePC, enable_fetch, enable_decode, enable_execute} <= 4'b1111;
                     end
`ifdef LC3_PIPE_CTRL_BYPASS_EN
                     bypass_mem_1 <= raw_mem_1;
                     bypass_mem_2 <= raw_mem_2;
`endif
                  end
               end
            end
            StFlush: begin
               if (cnt >= CNT_W'(BR_FLUSH_CYC)) begin
                  state <= StRun;
                  {enable_updatePC, enable_fetch, enable_decode, enable_execute,
                   enable_writeback} <= 5'b11111;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            default: state <= StFill;
         endcase
      end
   end

endmodule

// File: tb/tb_lc3_pipe_ctrl.sv
// Scoreboard bench for lc3_pipe_ctrl: stimulus pushes expected output vectors,
// a monitor pops and compares them on each falling edge (or on demand).
module tb_lc3_pipe_ctrl;

   logic        clock, reset, complete_instr, complete_data;
   logic [15:0] IR, IR_Exec;
   logic [2:0]  NZP, psr;
   logic        enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback;
   logic        br_taken, bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2;
   logic [1:0]  mem_state;
   logic [11:0] act;

   typedef struct {
      string       name;
      logic [11:0] v;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;
   event sample_ev;

   localparam logic [4:0] EN_ALL  = 5'b11111;
   localparam logic [4:0] EN_NONE = 5'b00000;
   localparam logic [4:0] EN_RST  = 5'b11000;
   localparam logic [4:0] EN_F1   = 5'b11100;
   localparam logic [4:0] EN_F2   = 5'b11110;
   localparam logic [4:0] EN_NOWB = 5'b11110;
   localparam logic [4:0] EN_WAIT = 5'b00001;
   localparam logic [4:0] EN_STL  = 5'b00011;
   localparam logic [3:0] B0      = 4'b0000;

   lc3_pipe_ctrl dut (
      .clock            (clock),
      .reset            (reset),
      .complete_instr   (complete_instr),
      .complete_data    (complete_data),
      .IR               (IR),
      .IR_Exec          (IR_Exec),
      .NZP              (NZP),
      .psr              (psr),
      .enable_updatePC  (enable_updatePC),
      .enable_fetch     (enable_fetch),
      .enable_decode    (enable_decode),
      .enable_execute   (enable_execute),
      .enable_writeback (enable_writeback),
      .br_taken         (br_taken),
      .bypass_alu_1     (bypass_alu_1),
      .bypass_alu_2     (bypass_alu_2),
      .bypass_mem_1     (bypass_mem_1),
      .bypass_mem_2     (bypass_mem_2),
      .mem_state        (mem_state)
   );

   assign act = {enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback,
                 br_taken, bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2, mem_state};

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   function automatic logic [11:0] ev(input logic [4:0] en, input logic br, input logic [3:0] byp,
                                      input logic [1:0] ms);
      return {en, br, byp, ms};
   endfunction

   task automatic expect_now(input string name, input logic [11:0] v);
      exp_t t;
      t.name = name;
      t.v    = v;
      q.push_back(t);
   endtask

   // Inputs are already set by the caller; the expectation is for the outputs after this edge
   task automatic step(input string name, input logic [11:0] v);
      @(posedge clock);
      expect_now(name, v);
      #1;
   endtask

   task automatic idle_inputs();
      complete_instr = 1'b1;
      complete_data  = 1'b0;
      IR             = 16'hF000;
      IR_Exec        = 16'hF000;
      NZP            = 3'b000;
      psr            = 3'b000;
   endtask

   // Monitor: compare DUT outputs against the oldest expectation
   initial begin
      exp_t e;
      forever begin
         @(negedge clock or sample_ev);
         if (q.size() > 0) begin
            e = q.pop_front();
            total++;
            if (act !== e.v) begin
               bad++;
               $display("FAIL %s: got %b want %b", e.name, act, e.v);
            end
         end
      end
   end

   initial begin
      idle_inputs();
      reset = 1'b0;
      expect_now("reset", ev(EN_RST, 1'b0, B0, 2'b11));
      @(posedge clock);
      @(posedge clock);
      #1;
      reset = 1'b1;

      step("fill1", ev(EN_F1, 1'b0, B0, 2'b11));
      step("fill2", ev(EN_F2, 1'b0, B0, 2'b11));
      step("fill3", ev(EN_ALL, 1'b0, B0, 2'b11));
      step("run", ev(EN_ALL, 1'b0, B0, 2'b11));
      complete_instr = 1'b0;
      step("instr_wait", ev(EN_WAIT, 1'b0, B0, 2'b11));
      complete_instr = 1'b1; complete_data = 1'b1;
      step("cd_ignored", ev(EN_ALL, 1'b0, B0, 2'b11));

      // LDR: read for three cycles, then a writeback pulse
      complete_data = 1'b0; IR_Exec = 16'h6042;
      step("ldr_enter", ev(EN_NONE, 1'b0, B0, 2'b00));
      IR_Exec = 16'hF000;
      step("ldr_wait1", ev(EN_NONE, 1'b0, B0, 2'b00));
      step("ldr_wait2", ev(EN_NONE, 1'b0, B0, 2'b00));
      complete_data = 1'b1;
      step("ldr_done", ev(EN_ALL, 1'b0, B0, 2'b11));
      complete_data = 1'b0;
      step("ldr_after", ev(EN_ALL, 1'b0, B0, 2'b11));

      // STI: indirect read, then write, no writeback
      IR_Exec = 16'hB201;
      step("sti_enter", ev(EN_NONE, 1'b0, B0, 2'b01));
      IR_Exec = 16'hF000;
      step("sti_wait_ind", ev(EN_NONE, 1'b0, B0, 2'b01));
      complete_data = 1'b1;
      step("sti_ind_done", ev(EN_NONE, 1'b0, B0, 2'b10));
      complete_data = 1'b0;
      step("sti_wait_wr", ev(EN_NONE, 1'b0, B0, 2'b10));
      complete_data = 1'b1;
      step("sti_done", ev(EN_NOWB, 1'b0, B0, 2'b11));
      complete_data = 1'b0;
      step("sti_after", ev(EN_ALL, 1'b0, B0, 2'b11));

      // LDI: indirect read, then read, writeback
      IR_Exec = 16'hA000;
      step("ldi_enter", ev(EN_NONE, 1'b0, B0, 2'b01));
      IR_Exec = 16'hF000; complete_data = 1'b1;
      step("ldi_ind_done", ev(EN_NONE, 1'b0, B0, 2'b00));
      step("ldi_done", ev(EN_ALL, 1'b0, B0, 2'b11));

      // ST entered while fetch is waiting: memory op takes priority
      complete_data = 1'b0; complete_instr = 1'b0; IR_Exec = 16'h3000;
      step("st_prio", ev(EN_NONE, 1'b0, B0, 2'b10));
      complete_instr = 1'b1; IR_Exec = 16'hF000; complete_data = 1'b1;
      step("st_done", ev(EN_NOWB, 1'b0, B0, 2'b11));
      complete_data = 1'b0;
      step("st_after", ev(EN_ALL, 1'b0, B0, 2'b11));

      // BRz taken: one-cycle pulse, two bubble cycles
      IR_Exec = 16'h0402; NZP = 3'b010; psr = 3'b010;
      step("brz_taken", ev(EN_RST, 1'b1, B0, 2'b11));
      IR_Exec = 16'hF000; NZP = 3'b000; psr = 3'b000;
      step("flush_1", ev(EN_RST, 1'b0, B0, 2'b11));
      step("flush_end", ev(EN_ALL, 1'b0, B0, 2'b11));
      IR_Exec = 16'h0402; NZP = 3'b010; psr = 3'b100;
      step("br_not_taken", ev(EN_ALL, 1'b0, B0, 2'b11));

      // JMP resolving while fetch waits still pulses
      IR_Exec = 16'hC1C0; NZP = 3'b000; psr = 3'b000; complete_instr = 1'b0;
      step("jmp_ci0", ev(EN_RST, 1'b1, B0, 2'b11));
      IR_Exec = 16'hF000; complete_instr = 1'b1;
      step("jmp_flush_1", ev(EN_RST, 1'b0, B0, 2'b11));
      step("jmp_flush_end", ev(EN_ALL, 1'b0, B0, 2'b11));

      // ALU -> ALU dependency
      IR_Exec = 16'h1261; IR = 16'h1441;
`ifdef LC3_PIPE_CTRL_BYPASS_EN
      step("alu_byp", ev(EN_ALL, 1'b0, 4'b1100, 2'b11));
      step("alu_byp_hold", ev(EN_ALL, 1'b0, 4'b1100, 2'b11));
      IR = 16'h1461;
      step("alu_byp_imm", ev(EN_ALL, 1'b0, 4'b1000, 2'b11));
`else
      step("alu_byp", ev(EN_STL, 1'b0, B0, 2'b11));
      step("alu_byp_hold", ev(EN_ALL, 1'b0, B0, 2'b11));
      IR = 16'h1461;
      step("alu_byp_imm", ev(EN_STL, 1'b0, B0, 2'b11));
`endif
      IR = 16'hF000; IR_Exec = 16'hF000;
      step("byp_clear", ev(EN_ALL, 1'b0, B0, 2'b11));

      // LD -> ALU dependency resolved at the end of the load
      IR_Exec = 16'h2200;
      step("ld_enter", ev(EN_NONE, 1'b0, B0, 2'b00));
      IR = 16'h1241; complete_data = 1'b1;
`ifdef LC3_PIPE_CTRL_BYPASS_EN
      step("ld_mem_byp", ev(EN_ALL, 1'b0, 4'b0011, 2'b11));
`else
      step("ld_mem_byp", ev(EN_STL, 1'b0, B0, 2'b11));
`endif
      idle_inputs();
      step("ld_after", ev(EN_ALL, 1'b0, B0, 2'b11));

      // Reset asserted mid-access takes effect without a clock edge
      IR_Exec = 16'hB201;
      step("sti2_enter", ev(EN_NONE, 1'b0, B0, 2'b01));
      IR_Exec = 16'hF000;
      @(negedge clock);
      #1;
      reset = 1'b0;
      #1;
      expect_now("async_reset", ev(EN_RST, 1'b0, B0, 2'b11));
      -> sample_ev;
      @(posedge clock);
      #1;
      reset = 1'b1;
      step("refill1", ev(EN_F1, 1'b0, B0, 2'b11));
      step("refill2", ev(EN_F2, 1'b0, B0, 2'b11));
      step("refill3", ev(EN_ALL, 1'b0, B0, 2'b11));

      @(negedge clock);
      #1;
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL queue_drain: got %0d pending want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
